// File: rtl/crossing_signal_monitor.sv
// Pedestrian-crossing companion: debounces the push-button into a held request and
// polices the controller's lamp outputs, latching a fault and flashing red on violation.
module crossing_signal_monitor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MIN_YELLOW      = 3,
  parameter int unsigned MIN_RED         = 5,
  parameter int unsigned FLASH_HALF      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw_i,
  input  logic       car_red_i,
  input  logic       car_yellow_i,
  input  logic       car_green_i,
  input  logic       ped_walk_i,
  input  logic       clear_fault_i,
  output logic       ped_btn_o,
  output logic       fault_o,
  output logic [2:0] fault_code_o,
  output logic       flash_red_o
);

  localparam logic [7:0] DebLvl    = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] MinYellow = 8'(MIN_YELLOW);
  localparam logic [7:0] MinRed    = 8'(MIN_RED);
  localparam logic [7:0] FlashLast = 8'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    MonInit,
    MonGreen,
    MonYellow,
    MonRed,
    MonFault
  } mon_state_e;

  mon_state_e state_q, state_d, lamp_state;

  logic       sync1_q, sync2_q;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic       press_q, press_d;
  logic       ped_btn_q, ped_btn_d;
  logic [7:0] dwell_q, dwell_d;
  logic [2:0] code_q, code_d;
  logic       flash_q, flash_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic [2:0] viol;
  logic       is_g, is_y, is_r, illegal, walk_conflict, legal_next;

  // Button front end: synchronizer, saturating debounce counter, single-shot press event.
  always_comb begin
    deb_cnt_d = 8'd0;
    if (sync2_q) begin
      deb_cnt_d = (deb_cnt_q == 8'hFF) ? deb_cnt_q : deb_cnt_q + 8'd1;
    end
    press_d = (deb_cnt_d == DebLvl) && (deb_cnt_q != DebLvl);
  end

  always_comb begin
    is_g          = car_green_i & ~car_yellow_i & ~car_red_i;
    is_y          = ~car_green_i & car_yellow_i & ~car_red_i;
    is_r          = ~car_green_i & ~car_yellow_i & car_red_i;
    illegal       = ~(is_g | is_y | is_r);
    walk_conflict = ped_walk_i & (is_g | is_y);
    lamp_state    = MonInit;
    if (is_g) lamp_state = MonGreen;
    if (is_y) lamp_state = MonYellow;
    if (is_r) lamp_state = MonRed;
    legal_next = ((state_q == MonGreen)  && (lamp_state == MonYellow)) ||
                 ((state_q == MonYellow) && (lamp_state == MonRed))    ||
                 ((state_q == MonRed)    && (lamp_state == MonGreen));
  end

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    code_d      = code_q;
    flash_d     = flash_q;
    flash_cnt_d = flash_cnt_q;
    viol        = 3'd0;
    unique case (state_q)
      MonInit: begin
        if (illegal) begin
          viol = 3'd1;
        end else if (walk_conflict) begin
          viol = 3'd2;
        end else begin
          state_d = lamp_state;
          dwell_d = 8'd1;
        end
      end
      MonGreen, MonYellow, MonRed: begin
        // Checks ordered so the lowest fault code wins.
        if (illegal) begin
          viol = 3'd1;
        end else if (walk_conflict) begin
          viol = 3'd2;
        end else if (lamp_state == state_q) begin
          dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
        end else if (!legal_next) begin
          viol = 3'd3;
        end else if ((state_q == MonYellow) && (dwell_q < MinYellow)) begin
          viol = 3'd4;
        end else if ((state_q == MonRed) && (dwell_q < MinRed)) begin
          viol = 3'd5;
        end else begin
          state_d = lamp_state;
          dwell_d = 8'd1;
        end
      end
      MonFault: begin
        if (clear_fault_i) begin
          state_d     = MonInit;
          code_d      = 3'd0;
          flash_d     = 1'b0;
          flash_cnt_d = 8'd0;
          dwell_d     = 8'd0;
        end else if (flash_cnt_q >= FlashLast) begin
          flash_d     = ~flash_q;
          flash_cnt_d = 8'd0;
        end else begin
          flash_cnt_d = flash_cnt_q + 8'd1;
        end
      end
      default: state_d = MonInit;
    endcase
    if (viol != 3'd0) begin
      state_d     = MonFault;
      code_d      = viol;
      flash_d     = 1'b1;
      flash_cnt_d = 8'd0;
      dwell_d     = 8'd0;
    end
  end

  // Walk acknowledge and the fault state both override a same-cycle press event.
  always_comb begin
    ped_btn_d = ped_btn_q;
    if ((state_q == MonFault) || (state_d == MonFault) || ped_walk_i) begin
      ped_btn_d = 1'b0;
    end else if (press_q) begin
      ped_btn_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_cnt_q   <= 8'd0;
      press_q     <= 1'b0;
      ped_btn_q   <= 1'b0;
      state_q     <= MonInit;
      dwell_q     <= 8'd0;
      code_q      <= 3'd0;
      flash_q     <= 1'b0;
      flash_cnt_q <= 8'd0;
    end else begin
      sync1_q     <= btn_raw_i;
      sync2_q     <= sync1_q;
      deb_cnt_q   <= deb_cnt_d;
      press_q     <= press_d;
      ped_btn_q   <= ped_btn_d;
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      code_q      <= code_d;
      flash_q     <= flash_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  assign ped_btn_o    = ped_btn_q;
  assign fault_o      = (state_q == MonFault);
  assign fault_code_o = code_q;
  assign flash_red_o  = flash_q;

endmodule

// File: tb/tb_crossing_signal_monitor.sv
// Directed bench for crossing_signal_monitor: button debounce/ack, lamp rule checks,
// flashing fail-safe, fault clear and asynchronous reset.
module tb_crossing_signal_monitor;

  logic       clk;
  logic       rst_n;
  logic       btn_raw, car_red, car_yellow, car_green, ped_walk, clear_fault;
  logic       ped_btn, fault, flash_red;
  logic [2:0] fault_code;

  int n_tests = 0;
  int n_fail  = 0;

  crossing_signal_monitor #(
    .DEBOUNCE_CYCLES(4),
    .MIN_YELLOW     (3),
    .MIN_RED        (5),
    .FLASH_HALF     (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw_i    (btn_raw),
    .car_red_i    (car_red),
    .car_yellow_i (car_yellow),
    .car_green_i  (car_green),
    .ped_walk_i   (ped_walk),
    .clear_fault_i(clear_fault),
    .ped_btn_o    (ped_btn),
    .fault_o      (fault),
    .fault_code_o (fault_code),
    .flash_red_o  (flash_red)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_code(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic lamps(input logic g, input logic y, input logic r);
    car_green  = g;
    car_yellow = y;
    car_red    = r;
  endtask

  task automatic clear_pulse();
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
  endtask

  initial begin
    logic [6:0] bounce;
    rst_n = 1'b0;
    btn_raw = 1'b0;
    ped_walk = 1'b0;
    clear_fault = 1'b0;
    lamps(1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_ped_btn", ped_btn, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk_code("rst_code", fault_code, 3'd0);
    chk("rst_flash", flash_red, 1'b0);

    // Clean press: btn high before edge 1, request after edge 7, ack at edge 12.
    @(negedge clk);
    rst_n = 1'b1;
    lamps(1'b0, 1'b0, 1'b1);
    btn_raw = 1'b1;
    repeat (6) tick();
    chk("press_edge6", ped_btn, 1'b0);
    tick();
    chk("press_edge7", ped_btn, 1'b1);
    repeat (4) tick();
    chk("press_held", ped_btn, 1'b1);
    ped_walk = 1'b1;
    tick();
    chk("ack_edge12", ped_btn, 1'b0);
    ped_walk = 1'b0;
    repeat (5) tick();
    chk("no_refire_held", ped_btn, 1'b0);
    btn_raw = 1'b0;
    repeat (3) tick();

    // Bounce pattern never reaches four consecutive highs.
    bounce = 7'b0111011;
    for (int i = 6; i >= 0; i--) begin
      btn_raw = bounce[i];
      tick();
    end
    btn_raw = 1'b0;
    repeat (4) tick();
    chk("bounce_no_req", ped_btn, 1'b0);
    btn_raw = 1'b1;
    repeat (6) tick();
    chk("hold_edge6", ped_btn, 1'b0);
    tick();
    chk("hold_edge7", ped_btn, 1'b1);
    ped_walk = 1'b1;
    tick();
    chk("hold_ack", ped_btn, 1'b0);
    ped_walk = 1'b0;
    repeat (10) tick();
    chk("single_request", ped_btn, 1'b0);
    btn_raw = 1'b0;
    repeat (3) tick();

    // Press while walk is high is discarded.
    ped_walk = 1'b1;
    btn_raw = 1'b1;
    repeat (10) tick();
    chk("press_during_walk", ped_btn, 1'b0);
    ped_walk = 1'b0;
    repeat (3) tick();
    chk("press_during_walk_after", ped_btn, 1'b0);
    btn_raw = 1'b0;
    repeat (3) tick();
    chk("no_fault_btn_phase", fault, 1'b0);

    // Legal cycle G10, Y3 (exact minimum), R+walk 5 (exact minimum), G.
    lamps(1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    chk("legal_green", fault, 1'b0);
    lamps(1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("legal_yellow", fault, 1'b0);
    lamps(1'b0, 1'b0, 1'b1);
    ped_walk = 1'b1;
    repeat (5) tick();
    chk("legal_red_walk", fault, 1'b0);
    ped_walk = 1'b0;
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    chk("legal_back_green", fault, 1'b0);

    // Short yellow: two yellow samples then red.
    repeat (2) tick();
    lamps(1'b0, 1'b1, 1'b0);
    repeat (2) tick();
    chk("short_y_pre", fault, 1'b0);
    lamps(1'b0, 0, 1'b1);
    tick();
    chk("short_y_fault", fault, 1'b1);
    chk_code("short_y_code", fault_code, 3'd4);
    chk("flash_0", flash_red, 1'b1);
    tick();
    chk("flash_1", flash_red, 1'b1);
    tick();
    chk("flash_2", flash_red, 1'b0);
    tick();
    chk("flash_3", flash_red, 1'b0);
    tick();
    chk("flash_4", flash_red, 1'b1);
    btn_raw = 1'b1;
    repeat (8) tick();
    chk("fault_press_ignored", ped_btn, 1'b0);
    chk("fault_held", fault, 1'b1);
    chk_code("fault_code_held", fault_code, 3'd4);
    btn_raw = 1'b0;
    repeat (3) tick();

    // Recovery into Init, yellow first sample accepted, then short red.
    lamps(1'b0, 1'b1, 1'b0);
    clear_pulse();
    chk("clr_fault", fault, 1'b0);
    chk_code("clr_code", fault_code, 3'd0);
    chk("clr_flash", flash_red, 1'b0);
    chk("clr_ped_btn", ped_btn, 1'b0);
    tick();
    chk("init_yellow_ok", fault, 1'b0);
    repeat (2) tick();
    lamps(1'b0, 1'b0, 1'b1);
    tick();
    chk("init_y_to_r_ok", fault, 1'b0);
    repeat (3) tick();
    lamps(1'b1, 1'b0, 1'b0);
    tick();
    chk("short_red_fault", fault, 1'b1);
    chk_code("short_red_code", fault_code, 3'd5);

    // Sequence violation beats nothing else here: G->R with walk.
    clear_pulse();
    repeat (2) tick();
    lamps(1'b0, 1'b0, 1'b1);
    ped_walk = 1'b1;
    tick();
    chk_code("g_to_r_code", fault_code, 3'd3);
    ped_walk = 1'b0;
    lamps(1'b1, 1'b0, 1'b0);
    clear_pulse();
    tick();
    lamps(1'b1, 1'b1, 1'b0);
    tick();
    chk_code("g_plus_y_code", fault_code, 3'd1);
    lamps(1'b1, 1'b0, 1'b0);
    clear_pulse();
    tick();
    ped_walk = 1'b1;
    tick();
    chk_code("walk_in_g_code", fault_code, 3'd2);
    chk("walk_in_g_flash", flash_red, 1'b1);

    // Asynchronous reset while faulted.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fault", fault, 1'b0);
    chk_code("async_rst_code", fault_code, 3'd0);
    chk("async_rst_flash", flash_red, 1'b0);
    chk("async_rst_ped_btn", ped_btn, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
